tweet_buffer: RTL and testbench

TWEET_BUFFER -- requirements
Module: tweet_buffer

---
 rtl/tweet_buffer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_tweet_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tweet_buffer.sv
// -----------------------------------------------------------------------------
// tweet_buffer
//
// Serial message recorder/player. Characters arriving on a UART-style line are
// stored in a small RAM (backspace removes the last one). A play pulse
// retransmits the stored message on tx, frames back-to-back. When playback is
// idle, tx optionally echoes rx.
//
// Ports
//   sysclk     in   single clock, all logic on the rising edge
//   reset      in   synchronous, active-high
//   rx         in   serial receive line (idle high, already synchronised)
//   play       in   one-cycle pulse, start playback of the stored message
//   clear      in   one-cycle pulse, discard the stored message / abort playback
//   tx         out  serial transmit line (idle high)
//   busy       out  high while playback is in progress
//   count      out  number of stored characters
//   full       out  count == DEPTH
//   frame_err  out  one-cycle pulse when a received frame has a bad stop bit
//   drop       out  one-cycle pulse when a valid character could not be stored
// -----------------------------------------------------------------------------
module tweet_buffer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 160,
    parameter int DATA_BITS    = 8,
    parameter int ECHO         = 1,
    localparam int ADDR_W      = $clog2(DEPTH + 1)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rx,
    input  logic              play,
    input  logic              clear,
    output logic              tx,
    output logic              busy,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              frame_err,
    output logic              drop
);

    localparam int TW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = $clog2(DATA_BITS + 1);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] BIT_M2  = TW'(CLKS_PER_BIT - 2);
    localparam logic [TW-1:0] BIT_M3  = TW'(CLKS_PER_BIT - 3);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] BACKSPACE = DATA_BITS'(8'h08);

    // -------------------------------------------------------------------------
    // Receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t              rx_state, rx_state_nxt;
    logic [TW-1:0]          rx_timer, rx_timer_nxt;
    logic [BW-1:0]          rx_bits, rx_bits_nxt;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_nxt;
    logic                   rx_ok, rx_ok_nxt;     // good stop bit seen last cycle
    logic                   rx_bad, rx_bad_nxt;   // bad stop bit seen last cycle

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_timer_nxt = rx_timer + 1'b1;
        rx_bits_nxt  = rx_bits;
        rx_shift_nxt = rx_shift;
        rx_ok_nxt    = 1'b0;
        rx_bad_nxt   = 1'b0;
        case (rx_state)
            R_IDLE: begin
                rx_timer_nxt = '0;
                if (!rx) rx_state_nxt = R_START;
            end
            R_START: begin
                // Re-check the start bit at its centre; a high line is a glitch.
                if (rx_timer == HALF_M1) begin
                    rx_timer_nxt = '0;
                    rx_bits_nxt  = '0;
                    rx_state_nxt = rx ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_timer == BIT_M1) begin
                    rx_timer_nxt = '0;
                    rx_shift_nxt = rx_shift >> 1;
                    rx_shift_nxt[DATA_BITS-1] = rx;
                    rx_bits_nxt  = rx_bits + 1'b1;
                    if (rx_bits == LAST_BIT) rx_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_timer == BIT_M1) begin
                    rx_timer_nxt = '0;
                    rx_state_nxt = R_IDLE;
                    rx_ok_nxt    = rx;
                    rx_bad_nxt   = !rx;
                end
            end
            default: begin
                rx_timer_nxt = '0;
                rx_state_nxt = R_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_state <= R_IDLE;
            rx_timer <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_ok    <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_timer <= rx_timer_nxt;
            rx_bits  <= rx_bits_nxt;
            rx_shift <= rx_shift_nxt;
            rx_ok    <= rx_ok_nxt;
            rx_bad   <= rx_bad_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Message store
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_data;
    logic                 is_bs;
    logic                 wr_en;
    logic [ADDR_W-1:0]    tx_idx;

    assign full  = (count == ADDR_W'(DEPTH));
    assign is_bs = (rx_shift == BACKSPACE);
    assign wr_en = rx_ok && !is_bs && !busy && !full;

    // NOTE: the RAM has no reset; clearing it would prevent block-RAM inference
    // and stale contents beyond count are never read.
    always_ff @(posedge sysclk) begin
        if (wr_en) mem[count[MEM_AW-1:0]] <= rx_shift;
        rd_data <= mem[tx_idx[MEM_AW-1:0]];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count     <= '0;
            drop      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            drop      <= 1'b0;
            frame_err <= rx_bad;
            if (rx_ok) begin
                if (is_bs) begin
                    // Backspace is silently ignored while empty or playing.
                    if (!busy && count != '0) count <= count - 1'b1;
                end else if (!busy && !full) begin
                    count <= count + 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end
            if (clear) count <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Transmitter
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_STOP, T_NEXT} tx_state_t;

    tx_state_t            tx_state, tx_state_nxt;
    logic [TW-1:0]        tx_timer, tx_timer_nxt;
    logic [BW-1:0]        tx_bits, tx_bits_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic [ADDR_W-1:0]    tx_idx_nxt, tx_snap, tx_snap_nxt;
    logic [ADDR_W-1:0]    idx_inc;
    logic                 last;
    logic                 tx_bit;

    assign idx_inc = tx_idx + 1'b1;
    assign last    = (idx_inc == tx_snap);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_timer_nxt = tx_timer + 1'b1;
        tx_bits_nxt  = tx_bits;
        tx_shift_nxt = tx_shift;
        tx_idx_nxt   = tx_idx;
        tx_snap_nxt  = tx_snap;
        tx_bit       = 1'b1;
        case (tx_state)
            T_IDLE: begin
                tx_timer_nxt = '0;
                if (play && count != '0) begin
                    tx_state_nxt = T_LOAD;
                    tx_idx_nxt   = '0;
                    tx_snap_nxt  = count;
                end
            end
            T_LOAD: begin
                // RAM address is stable this cycle; data is ready in T_START.
                tx_timer_nxt = '0;
                tx_state_nxt = T_START;
            end
            T_START: begin
                tx_bit = 1'b0;
                if (tx_timer == BIT_M1) begin
                    tx_timer_nxt = '0;
                    tx_bits_nxt  = '0;
                    tx_shift_nxt = rd_data;
                    tx_state_nxt = T_DATA;
                end
            end
            T_DATA: begin
                tx_bit = tx_shift[0];
                if (tx_timer == BIT_M1) begin
                    tx_timer_nxt = '0;
                    tx_shift_nxt = tx_shift >> 1;
                    tx_bits_nxt  = tx_bits + 1'b1;
                    if (tx_bits == LAST_BIT) tx_state_nxt = T_STOP;
                end
            end
            T_STOP: begin
                // T_NEXT (and T_LOAD when another character follows) complete
                // the stop period, so the stop bit is shortened accordingly.
                if (tx_timer == (last ? BIT_M2 : BIT_M3)) begin
                    tx_timer_nxt = '0;
                    tx_state_nxt = T_NEXT;
                end
            end
            T_NEXT: begin
                tx_timer_nxt = '0;
                if (last) begin
                    tx_state_nxt = T_IDLE;
                end else begin
                    tx_idx_nxt   = idx_inc;
                    tx_state_nxt = T_LOAD;
                end
            end
            default: begin
                tx_timer_nxt = '0;
                tx_state_nxt = T_IDLE;
            end
        endcase
        if (clear) begin
            tx_state_nxt = T_IDLE;
            tx_timer_nxt = '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state <= T_IDLE;
            tx_timer <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_idx   <= '0;
            tx_snap  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_timer <= tx_timer_nxt;
            tx_bits  <= tx_bits_nxt;
            tx_shift <= tx_shift_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_snap  <= tx_snap_nxt;
        end
    end

    assign busy = (tx_state != T_IDLE);

    always_comb begin
        tx = 1'b1;
        if (reset)         tx = 1'b1;
        else if (busy)     tx = tx_bit;
        else if (ECHO != 0) tx = rx;
    end

endmodule

// File: tb/tb_tweet_buffer.sv
// -----------------------------------------------------------------------------
// tb_tweet_buffer
//
// Directed self-checking bench for tweet_buffer with CLKS_PER_BIT=16, DEPTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tweet_buffer;

    localparam int CPB    = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH + 1);

    logic              sysclk = 1'b0;
    logic              reset;
    logic              rx;
    logic              play;
    logic              clear;
    logic              tx;
    logic              busy;
    logic [ADDR_W-1:0] count;
    logic              full;
    logic              frame_err;
    logic              drop;

    int checks = 0;
    int errors = 0;
    int drop_seen = 0;
    int ferr_seen = 0;
    int k = 0;
    int d0, f0;

    tweet_buffer #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH),
        .DATA_BITS   (8),
        .ECHO        (1)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .rx       (rx),
        .play     (play),
        .clear    (clear),
        .tx       (tx),
        .busy     (busy),
        .count    (count),
        .full     (full),
        .frame_err(frame_err),
        .drop     (drop)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (drop === 1'b1)      drop_seen++;
        if (frame_err === 1'b1) ferr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Drives play for one cycle; returns at the first cycle after the play cycle.
    task automatic start_play();
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    task automatic adv_to(input int t);
        while (k < t) begin
            tick();
            k++;
        end
    endtask

    // Checks tx at the centre of each of the 10 bits of frame f (k=0 is the
    // first cycle of the first start bit).
    task automatic check_frame(input int f, input logic [7:0] b);
        logic exp;
        for (int i = 0; i < 10; i++) begin
            adv_to(10 * CPB * f + CPB * i + CPB / 2);
            if (i == 0)      exp = 1'b0;
            else if (i == 9) exp = 1'b1;
            else             exp = b[i-1];
            check($sformatf("frame%0d_bit%0d", f, i), {31'd0, tx}, {31'd0, exp});
        end
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        play  = 1'b0;
        clear = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_tx",        {31'd0, tx},        32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_count",     {29'd0, count},     32'd0);
        check("rst_full",      {31'd0, full},      32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_drop",      {31'd0, drop},      32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Echo while idle; a short low pulse is a start glitch with no flag
        rx = 1'b0;
        #1;
        check("echo_low", {31'd0, tx}, 32'd0);
        tick();
        rx = 1'b1;
        repeat (20) tick();
        check("glitch_count", {29'd0, count}, 32'd0);
        check("glitch_ferr",  ferr_seen,      32'd0);

        // Store "AB"
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        check("ab_count", {29'd0, count}, 32'd2);
        check("ab_full",  {31'd0, full},  32'd0);
        check("ab_drop",  drop_seen,      32'd0);
        check("ab_ferr",  ferr_seen,      32'd0);

        // Play "AB": start bit two cycles after play, 20 bit periods total
        start_play();
        check("play_busy", {31'd0, busy}, 32'd1);
        check("play_tx_hi", {31'd0, tx},  32'd1);
        tick();
        k = 0;
        check("play_start_latency", {31'd0, tx}, 32'd0);
        check_frame(0, 8'h41);
        check_frame(1, 8'h42);
        adv_to(20 * CPB - 1);
        check("play_busy_last", {31'd0, busy}, 32'd1);
        adv_to(20 * CPB);
        check("play_busy_fall", {31'd0, busy}, 32'd0);
        check("play_count_kept", {29'd0, count}, 32'd2);

        // Overflow and backspace
        pulse_clear();
        check("clear_count", {29'd0, count}, 32'd0);
        d0 = drop_seen;
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h45, 1'b1);
        check("ovf_count", {29'd0, count}, 32'd4);
        check("ovf_full",  {31'd0, full},  32'd1);
        check("ovf_drops", drop_seen - d0, 32'd1);
        send_frame(8'h08, 1'b1);
        check("bs_count", {29'd0, count}, 32'd3);
        check("bs_full",  {31'd0, full},  32'd0);

        // Bad stop bit, then backspace on an empty buffer
        f0 = ferr_seen;
        d0 = drop_seen;
        send_frame(8'h55, 1'b0);
        check("ferr_pulses", ferr_seen - f0, 32'd1);
        check("ferr_count",  {29'd0, count}, 32'd3);
        check("ferr_drops",  drop_seen - d0, 32'd0);
        pulse_clear();
        send_frame(8'h08, 1'b1);
        check("bs_empty_count", {29'd0, count}, 32'd0);

        // Clear during the second character of playback
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        check("abort_pre_count", {29'd0, count}, 32'd2);
        start_play();
        tick();
        k = 0;
        adv_to(10 * CPB + CPB + CPB / 2);
        check("abort_pre_tx",   {31'd0, tx},   32'd0);
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        pulse_clear();
        check("abort_tx",    {31'd0, tx},    32'd1);
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_count", {29'd0, count}, 32'd0);
        start_play();
        check("abort_replay_busy", {31'd0, busy}, 32'd0);
        tick();
        check("abort_replay_busy2", {31'd0, busy}, 32'd0);
        check("abort_replay_tx",    {31'd0, tx},   32'd1);

        // Reset in the middle of a received frame
        send_frame(8'h41, 1'b1);
        check("prereset_count", {29'd0, count}, 32'd1);
        rx = 1'b0;
        repeat (CPB + 20) tick();
        reset = 1'b1;
        tick();
        check("midrx_reset_tx",    {31'd0, tx},    32'd1);
        check("midrx_reset_count", {29'd0, count}, 32'd0);
        rx = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        f0 = ferr_seen;
        send_frame(8'h5A, 1'b1);
        check("postreset_count", {29'd0, count}, 32'd1);
        check("postreset_ferr",  ferr_seen - f0, 32'd0);
        start_play();
        tick();
        k = 0;
        check_frame(0, 8'h5A);
        adv_to(10 * CPB - 1);
        check("postreset_busy_last", {31'd0, busy}, 32'd1);
        adv_to(10 * CPB);
        check("postreset_busy_fall", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
